// File: rtl/hdc_pkg.sv
// hdc_pkg: shared hypervector width, per-channel binding shift table and vector type.
package hdc_pkg;
   localparam int HV_DIM = 1024;
   localparam int N_SHIFTS = 16;
   localparam int SHIFTS [N_SHIFTS] = '{3, 17, 10, 5, 0, 1, 15, 8, 31, 7, 2, 4, 6, 9, 11, 12};
   typedef logic [HV_DIM-1:0] hv_t;
endpackage

// File: rtl/enc_binder_bank_if.sv
// enc_binder_bank_if: request/response bundle between the encoder front end and the binder bank.
interface enc_binder_bank_if #(
   parameter int HV_DIM = hdc_pkg::HV_DIM,
   parameter int N_CH = 10
);
   logic start;
   logic mode;
   logic busy;
   logic done;
   logic [HV_DIM-1:0] level_hv [N_CH];
   logic [HV_DIM-1:0] shifted_hv [N_CH];
   modport master (output start, mode, level_hv, input shifted_hv, busy, done);
   modport slave (input start, mode, level_hv, output shifted_hv, busy, done);
endinterface

// File: rtl/enc_lane_rotator.sv
// enc_lane_rotator: combinational log-depth left rotator, whole-vector or per-segment.
module enc_lane_rotator #(
   parameter int HV_DIM = hdc_pkg::HV_DIM,
   parameter int SEG_LEN = 64,
   localparam int SW = $clog2(HV_DIM)
) (
   input  logic [HV_DIM-1:0] hv,
   input  logic [SW-1:0]     shift,
   input  logic              mode,
   output logic [HV_DIM-1:0] rot
);
   for (genvar k = 0; k < SW; k++) begin : g_st
      localparam int R = 1 << k;
      localparam int RS = R % SEG_LEN;
      logic [HV_DIM-1:0] i, w, s, o;
      if (k == 0) begin : g_first
         assign i = hv;
      end else begin : g_next
         assign i = g_st[k-1].o;
      end
      assign w = {i[HV_DIM-1-R:0], i[HV_DIM-1:HV_DIM-R]};
      // A stage whose step is a multiple of SEG_LEN is never selected in segment mode
      for (genvar n = 0; n < HV_DIM / SEG_LEN; n++) begin : g_seg
         logic [SEG_LEN-1:0] x;
         assign x = i[n*SEG_LEN +: SEG_LEN];
         if (RS == 0) begin : g_id
            assign s[n*SEG_LEN +: SEG_LEN] = x;
         end else begin : g_rot
            assign s[n*SEG_LEN +: SEG_LEN] = {x[SEG_LEN-1-RS:0], x[SEG_LEN-1:SEG_LEN-RS]};
         end
      end
      assign o = shift[k] ? (mode ? s : w) : i;
   end
   assign rot = g_st[SW-1].o;
endmodule

// File: rtl/enc_binder_bank.sv
// enc_binder_bank: binds N_CH level hypervectors by per-channel rotation,
// reusing LANES rotators over ceil(N_CH/LANES) cycles.
module enc_binder_bank #(
   parameter int HV_DIM = hdc_pkg::HV_DIM,
   parameter int N_CH = 10,
   parameter int LANES = 5,
   parameter int BASE = 0,
   parameter int SEG_LEN = 64
) (
   input logic clk,
   input logic rst,
   enc_binder_bank_if.slave bus
);
   localparam int NGRP = (N_CH + LANES - 1) / LANES;
   localparam int GW = NGRP > 1 ? $clog2(NGRP) : 1;
   localparam int SW = $clog2(HV_DIM);
   typedef enum logic [1:0] {IDLE, BIND, DONE} state_t;
   if (HV_DIM % SEG_LEN != 0) begin : g_seg_chk
      $error("enc_binder_bank: SEG_LEN must divide HV_DIM");
   end
   if (LANES < 1 || LANES > N_CH) begin : g_lane_chk
      $error("enc_binder_bank: LANES must be in 1..N_CH");
   end
   if (BASE < 0 || BASE + N_CH > hdc_pkg::N_SHIFTS) begin : g_base_chk
      $error("enc_binder_bank: BASE+N_CH exceeds the shift table");
   end
   state_t state, state_nx;
   logic [GW-1:0] grp;
   logic load;
   logic in_mode;
   logic [HV_DIM-1:0] in_hv [N_CH];
   logic [HV_DIM-1:0] out_hv [N_CH];
   logic [HV_DIM-1:0] out_nx [N_CH];
   logic [HV_DIM-1:0] lane_out [LANES];
   always_comb begin
      load = bus.start && state != BIND;
      state_nx = load ? BIND
               : state == DONE ? IDLE
               : (state == BIND && grp == GW'(NGRP - 1)) ? DONE
               : state;
      bus.busy = state == BIND;
      bus.done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grp <= '0;
         in_mode <= 1'b0;
         in_hv <= '{default: '0};
         out_hv <= '{default: '0};
      end else begin
         state <= state_nx;
         grp <= load ? '0 : state == BIND ? grp + 1'b1 : grp;
         if (load) begin
            in_mode <= bus.mode;
            in_hv <= bus.level_hv;
         end
         out_hv <= out_nx;
      end
   end
   // Shift amounts are elaboration constants; only the group counter selects among them
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [HV_DIM-1:0] gin [NGRP];
      logic [SW-1:0] shw [NGRP];
      logic [SW-1:0] shs [NGRP];
      for (genvar g = 0; g < NGRP; g++) begin : g_grp
         localparam int C = g * LANES + l;
         if (C < N_CH) begin : g_ch
            assign gin[g] = in_hv[C];
            assign shw[g] = SW'(hdc_pkg::SHIFTS[BASE + C] % HV_DIM);
            assign shs[g] = SW'(hdc_pkg::SHIFTS[BASE + C] % SEG_LEN);
         end else begin : g_idle
            assign gin[g] = '0;
            assign shw[g] = '0;
            assign shs[g] = '0;
         end
      end
      enc_lane_rotator #(.HV_DIM(HV_DIM), .SEG_LEN(SEG_LEN)) u_rot (
         .hv(gin[grp]),
         .shift(in_mode ? shs[grp] : shw[grp]),
         .mode(in_mode),
         .rot(lane_out[l])
      );
   end
   for (genvar c = 0; c < N_CH; c++) begin : g_out
      assign out_nx[c] = (state == BIND && grp == GW'(c / LANES)) ? lane_out[c % LANES] : out_hv[c];
   end
   assign bus.shifted_hv = out_hv;
endmodule

// File: tb/tb_enc_binder_bank.sv
// tb_enc_binder_bank: scoreboard bench for the binder bank (HV_DIM=16, SEG_LEN=8, N_CH=10, LANES=4).
module tb_enc_binder_bank;
   localparam int HV = 16;
   localparam int NC = 10;
   localparam int LN = 4;
   localparam int SL = 8;
   typedef logic [NC-1:0][HV-1:0] vec_t;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   enc_binder_bank_if #(.HV_DIM(HV), .N_CH(NC)) b ();
   enc_binder_bank #(.HV_DIM(HV), .N_CH(NC), .LANES(LN), .BASE(0), .SEG_LEN(SL)) dut (
      .clk(clk), .rst(rst), .bus(b)
   );
   int n_cmp = 0;
   int n_bad = 0;
   vec_t exp_q[$];
   function automatic vec_t golden(vec_t hv, bit m);
      vec_t o;
      for (int c = 0; c < NC; c++) begin
         int s;
         s = hdc_pkg::SHIFTS[c];
         for (int j = 0; j < HV; j++)
            o[c][j] = m ? hv[c][(j / SL) * SL + (j % SL + SL - s % SL) % SL]
                        : hv[c][(j + HV - s % HV) % HV];
      end
      return o;
   endfunction
   function automatic vec_t outs();
      vec_t o;
      for (int c = 0; c < NC; c++) o[c] = b.shifted_hv[c];
      return o;
   endfunction
   function automatic vec_t rnd();
      vec_t o;
      for (int c = 0; c < NC; c++) o[c] = 16'($urandom);
      return o;
   endfunction
   task automatic set_in(input vec_t hv, input bit m);
      for (int c = 0; c < NC; c++) b.level_hv[c] = hv[c];
      b.mode = m;
   endtask
   task automatic launch(input vec_t hv, input bit m, input bit push);
      b.start = 1'b1;
      set_in(hv, m);
      if (push) exp_q.push_back(golden(hv, m));
   endtask
   // Runs one operation; inputs are scrambled right after start to prove they were captured
   task automatic run_op(input vec_t hv, input bit m, output int k_done, output int n_done,
                         output logic [8:1] bsy);
      @(negedge clk);
      launch(hv, m, 1'b1);
      k_done = 0;
      n_done = 0;
      bsy = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            b.start = 1'b0;
            set_in(~hv, ~m);
         end
         bsy[k] = b.busy;
         if (b.done) begin
            n_done++;
            if (k_done == 0) k_done = k;
         end
      end
   endtask
   task automatic test_reset();
      vec_t o;
      rst = 1'b1;
      b.start = 1'b0;
      set_in(rnd(), 1'b0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (b.busy !== 1'b0 || b.done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_flags busy=%b done=%b required 0/0", b.busy, b.done);
      end
      o = outs();
      for (int c = 0; c < NC; c++) begin
         n_cmp++;
         if (o[c] !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_out ch%0d got %h required 0000", c, o[c]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (b.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle busy=%b required 0", b.busy);
      end
   endtask
   task automatic test_whole();
      vec_t hv, e, o;
      int k_done, n_done;
      logic [8:1] bsy;
      hv = rnd();
      hv[0] = 16'h0001;
      hv[1] = 16'h8000;
      run_op(hv, 1'b0, k_done, n_done, bsy);
      n_cmp++;
      if (k_done !== 4 || n_done !== 1) begin
         n_bad++;
         $display("FAIL whole_done got k=%0d n=%0d required k=4 n=1", k_done, n_done);
      end
      n_cmp++;
      if (bsy !== 8'b0000_0111) begin
         n_bad++;
         $display("FAIL whole_busy got %b required 00000111", bsy);
      end
      o = outs();
      e = exp_q.pop_front();
      n_cmp++;
      if (o[0] !== 16'h0008) begin
         n_bad++;
         $display("FAIL whole_s3 got %h required 0008", o[0]);
      end
      n_cmp++;
      if (o[1] !== 16'h0001) begin
         n_bad++;
         $display("FAIL whole_s17 got %h required 0001", o[1]);
      end
      for (int c = 0; c < NC; c++) begin
         n_cmp++;
         if (o[c] !== e[c]) begin
            n_bad++;
            $display("FAIL whole_model ch%0d got %h required %h", c, o[c], e[c]);
         end
      end
   endtask
   task automatic test_segment();
      vec_t hv, e, o;
      int k_done, n_done;
      logic [8:1] bsy;
      for (int t = 0; t < 2; t++) begin
         hv = rnd();
         hv[0] = 16'h0080;
         hv[2] = t == 0 ? 16'h0080 : 16'h8000;
         run_op(hv, 1'b1, k_done, n_done, bsy);
         o = outs();
         e = exp_q.pop_front();
         n_cmp++;
         if (k_done !== 4) begin
            n_bad++;
            $display("FAIL seg_done got k=%0d required 4", k_done);
         end
         n_cmp++;
         if (o[2] !== (t == 0 ? 16'h0002 : 16'h0200)) begin
            n_bad++;
            $display("FAIL seg_s10 t%0d got %h required %h", t, o[2], t == 0 ? 16'h0002 : 16'h0200);
         end
         n_cmp++;
         if (o[0] !== 16'h0004) begin
            n_bad++;
            $display("FAIL seg_leak got %h required 0004", o[0]);
         end
         for (int c = 0; c < NC; c++) begin
            n_cmp++;
            if (o[c] !== e[c]) begin
               n_bad++;
               $display("FAIL seg_model ch%0d got %h required %h", c, o[c], e[c]);
            end
         end
      end
   endtask
   task automatic test_partial();
      vec_t hv, prev, e, o;
      prev = outs();
      hv = rnd();
      @(negedge clk);
      launch(hv, 1'b0, 1'b1);
      e = exp_q[$];
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) b.start = 1'b0;
         if (k >= 2) begin
            o = outs();
            for (int c = 0; c < NC; c++) begin
               n_cmp++;
               if (o[c] !== (c / LN <= k - 2 ? e[c] : prev[c])) begin
                  n_bad++;
                  $display("FAIL partial_k%0d ch%0d got %h required %h", k, c, o[c],
                           c / LN <= k - 2 ? e[c] : prev[c]);
               end
            end
         end
      end
      n_cmp++;
      if (b.done !== 1'b1) begin
         n_bad++;
         $display("FAIL partial_done got %b required 1", b.done);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (outs() [9:8] !== e[9:8]) begin
         n_bad++;
         $display("FAIL partial_ch89 got %h required %h", outs() [9:8], e[9:8]);
      end
   endtask
   task automatic test_ignore_start();
      vec_t a, e, o;
      int n_done;
      a = rnd();
      @(negedge clk);
      launch(a, 1'b0, 1'b1);
      n_done = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) b.start = 1'b0;
         if (k == 2) launch(rnd(), 1'b1, 1'b0);
         if (k == 3) b.start = 1'b0;
         if (b.done) n_done++;
         if (k == 4) begin
            n_cmp++;
            if (b.done !== 1'b1) begin
               n_bad++;
               $display("FAIL ignore_done_k4 got %b required 1", b.done);
            end
            o = outs();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL ignore_data got %h required %h", o, e);
            end
         end
      end
      n_cmp++;
      if (n_done !== 1) begin
         n_bad++;
         $display("FAIL ignore_count got %0d required 1", n_done);
      end
   endtask
   task automatic test_back_to_back();
      vec_t a, nb, e, o;
      a = rnd();
      nb = rnd();
      @(negedge clk);
      launch(a, 1'b0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1 || k == 5) b.start = 1'b0;
         if (k == 4 || k == 8) begin
            n_cmp++;
            if (b.done !== 1'b1) begin
               n_bad++;
               $display("FAIL b2b_done_k%0d got %b required 1", k, b.done);
            end
            o = outs();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
               n_bad++;
               $display("FAIL b2b_data_k%0d got %h required %h", k, o, e);
            end
         end else begin
            n_cmp++;
            if (b.done !== 1'b0) begin
               n_bad++;
               $display("FAIL b2b_spurious_k%0d done=%b required 0", k, b.done);
            end
         end
         if (k == 4) launch(nb, 1'b1, 1'b1);
      end
   endtask
   task automatic test_rst_bind();
      vec_t o;
      int n_done;
      @(negedge clk);
      launch(rnd(), 1'b0, 1'b0);
      n_done = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) b.start = 1'b0;
         if (b.done) n_done++;
         if (k == 2) rst = 1'b1;
         if (k == 3) begin
            rst = 1'b0;
            o = outs();
            n_cmp++;
            if (b.busy !== 1'b0 || o !== '0) begin
               n_bad++;
               $display("FAIL rst_bind busy=%b out=%h required 0/0", b.busy, o);
            end
         end
      end
      n_cmp++;
      if (n_done !== 0) begin
         n_bad++;
         $display("FAIL rst_bind_done got %0d required 0", n_done);
      end
   endtask
   task automatic test_rst_start();
      int n_act;
      @(negedge clk);
      rst = 1'b1;
      launch(rnd(), 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      b.start = 1'b0;
      n_act = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (b.busy || b.done) n_act++;
      end
      n_cmp++;
      if (n_act !== 0) begin
         n_bad++;
         $display("FAIL rst_start active_cycles got %0d required 0", n_act);
      end
   endtask
   initial begin
      test_reset();
      test_whole();
      test_segment();
      test_partial();
      test_ignore_start();
      test_back_to_back();
      test_rst_bind();
      test_rst_start();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/enc_binder_bank.md
# enc_binder_bank

Parametrised, time-multiplexed binder bank for the sparse HDC encoder. It binds `N_CH` level hypervectors to their channel positions by rotating each one by a per-channel constant from the shared shift table. A configurable number of physical lanes is reused over several cycles. Each operation runs in one of two modes: whole-vector rotate or segment-wise (block-sparse) rotate. The block replaces the fixed ten-wide binder packs in the encoder front end and reports completion with a `busy`/`done` handshake.

## Interface
- `HV_DIM`, default `HV_DIM` from the package; hypervector width in bits.
- `N_CH`, default 10; number of channels bound per operation.
- `LANES`, default 5; number of physical rotator lanes, 1 ≤ `LANES` ≤ `N_CH`.
- `BASE`, default 0; index into the package `SHIFTS` table for channel 0.
- `SEG_LEN`, default 64; segment length for segment mode. It must divide `HV_DIM`; violating this is an elaboration error.
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to bind the current `level_hv`.
- `mode`  in  1  0 = whole-vector rotate, 1 = segment rotate; sampled with `start`.
- `level_hv`  in  `HV_DIM` × [0:`N_CH`-1]  input hypervectors; sampled with `start`.
- `shifted_hv`  out  `HV_DIM` × [0:`N_CH`-1]  bound hypervectors, registered.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when every `shifted_hv` entry is valid.

## Operation
- Channel `c` uses shift `S_c = SHIFTS[BASE+c]`.
- Whole mode: `shifted_hv[c]` is `level_hv[c]` rotated left (toward the MSB) by `S_c mod HV_DIM`. Output bit `j` takes input bit `(j − S) mod HV_DIM`.
- Segment mode: each aligned `SEG_LEN` slice is rotated left independently by `S_c mod SEG_LEN`. No bits cross a segment boundary.
- Group count: `NGRP = ceil(N_CH/LANES)`. Group `g` covers channels `g*LANES … g*LANES+LANES-1`. Lanes beyond `N_CH−1` in the last group are idle, and their outputs are not written.
- The FSM has three states: IDLE, BIND, DONE.
  - IDLE: `start=1` captures `level_hv` and `mode` into an input register, clears the group counter, and moves to BIND.
  - BIND: each cycle writes the group at the counter into the `shifted_hv` registers and increments the counter. After group `NGRP−1` is written, the FSM moves to DONE.
  - DONE: `done=1` for one cycle, then IDLE.
  - A `start` seen in DONE is accepted exactly as in IDLE, so back-to-back operations are allowed.
- `start` while in BIND is ignored. No queuing, no error flag.
- `shifted_hv` holds its value after DONE until overwritten group by group by the next operation. Entries of groups not yet rewritten keep their previous results.
- Changes to `level_hv` or `mode` after the `start` cycle have no effect on the running operation.

## Timing
- Reset values: `busy=0`, `done=0`, every `shifted_hv` entry `0`, FSM in IDLE, counter `0`, input register `0`.
- `rst` overrides everything, including `start` in the same cycle. Reset during BIND aborts the operation: no `done` pulse, outputs cleared.
- Cycle T: `start` sampled. `busy` is high in cycles T+1 … T+`NGRP`.
- Group `g` is visible on `shifted_hv` from cycle T+2+`g`.
- `done` is high in cycle T+`NGRP`+1, with `busy=0`. All outputs are valid in that cycle.
- Latency from `start` to `done` is `NGRP`+1 cycles. With `LANES=N_CH` it is 2 cycles.
- Back-to-back: a `start` in the `done` cycle gives the next `done` `NGRP`+1 cycles later.

## Structure
- Shared package `hdc_pkg`: `HV_DIM`, the `SHIFTS` array, and a `hv_t` typedef (`logic [HV_DIM-1:0]`). The state enum (`IDLE`, `BIND`, `DONE`) is local.
- Per-group lane shifts are elaboration-time constants, selected by the group counter through a small mux. Width is `$clog2(HV_DIM)` bits, reduced mod `HV_DIM` / `SEG_LEN` at elaboration.
- Sub-module `enc_lane_rotator`: combinational log-depth barrel rotator. Inputs are `hv_t`, a runtime shift amount, and `mode`; parameter is `SEG_LEN`. Instantiated `LANES` times.

## Test plan
Bench parameters: `HV_DIM=16`, `SEG_LEN=8`, `N_CH=10`, `LANES=4` (so `NGRP=3`), with `SHIFTS` set per test.
- Whole mode, `S_0=3`, `level_hv[0]=16'h0001` → `shifted_hv[0]=16'h0008`. `done` exactly 4 cycles after `start`. `busy` high for cycles 1–3.
- Whole mode, `S_0=17`, input `16'h8000` → `16'h0001` (shift reduced mod 16).
- Segment mode, `S_0=10`, input `16'h0080` → `16'h0002`. Input `16'h8000` → `16'h0200`. No cross-segment leakage.
- Partial last group: channels 8 and 9 correct. Lanes 2–3 of group 2 write nothing. All 10 outputs match the golden model at `done`.
- `start` pulsed again in BIND cycle 2 → ignored, single `done`. `start` in the `done` cycle → second `done` 4 cycles later with the new data.
- `rst` asserted in BIND cycle 2 → next cycle `busy=0`, no `done`, all `shifted_hv` = `16'h0000`. `rst` and `start` in the same cycle → stays IDLE.
